// File: rtl/cen_quad_pkg.sv
// Shared definitions for the sound-CPU clock-enable generator.
//   ph_t         : quadrature phase; each name is the strobe fired when leaving it
//   CQ_*         : default divider width, reset divider, channel count, reset stages
//   ph_e / ph_q  : E/Q levels shown while sitting in a phase
package cen_quad_pkg;

  typedef enum logic [1:0] {
    PH_QR = 2'd0,  // (e,q)=(0,0), exit raises q
    PH_ER = 2'd1,  // (0,1), exit raises e
    PH_QF = 2'd2,  // (1,1), exit drops q
    PH_EF = 2'd3   // (1,0), exit drops e
  } ph_t;

  localparam int CQ_W          = 4;
  localparam int CQ_E_DIV_RST  = 0;
  localparam int CQ_NCH        = 2;
  localparam int CQ_RST_STAGES = 2;

  // Phase encoding is chosen so E is the MSB and Q is a Gray-style xor.
  function automatic logic ph_e(ph_t p);
    return p[1];
  endfunction

  function automatic logic ph_q(ph_t p);
    return p[1] ^ p[0];
  endfunction

endpackage

// File: rtl/cen_div.sv
// One auxiliary clock-enable channel.
//   rst      : async active-high reset
//   clk_base : clock
//   en       : channel enable; low clears the counter and suppresses pulses
//   div      : period minus 1
//   cen      : registered one-cycle enable pulse
module cen_div
  import cen_quad_pkg::*;
#(
  parameter int W = CQ_W
) (
  input  logic         rst,
  input  logic         clk_base,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         cen
);

  logic [W-1:0] a;

  // >= rather than == so that lowering div below the running count
  // terminates the period on the next cycle instead of after a wrap.
  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      a   <= '0;
      cen <= 1'b0;
    end else if (!en) begin
      a   <= '0;
      cen <= 1'b0;
    end else if (a >= div) begin
      a   <= '0;
      cen <= 1'b1;
    end else begin
      a   <= a + W'(1);
      cen <= 1'b0;
    end
  end

endmodule

// File: rtl/cen_quad_gen.sv
// Clock-enable generator: 6809-style quadrature E/Q, edge strobes, NCH aux
// enables and a CPU reset released in step with Q falling.
//   rst, clk_base             : async active-high reset, clock
//   e_div                     : quarter-period minus 1, latched at each ph3->ph0
//   hold                      : stretches E high while asserted at the ph3 terminal
//   aux_div[i*W +: W], aux_en : per-channel period minus 1 and enable
//   e, q                      : registered quadrature levels
//   e_rise/e_fall/q_rise/q_fall : one-cycle strobes, coincident with level change
//   aux_cen                   : per-channel one-cycle enables
//   rst_out                   : reset for the CPU domain, released on a q_fall
module cen_quad_gen
  import cen_quad_pkg::*;
#(
  parameter int W          = CQ_W,
  parameter int NCH        = CQ_NCH,
  parameter int E_DIV_RST  = CQ_E_DIV_RST,
  parameter int RST_STAGES = CQ_RST_STAGES
) (
  input  logic             rst,
  input  logic             clk_base,
  input  logic [W-1:0]     e_div,
  input  logic             hold,
  input  logic [NCH*W-1:0] aux_div,
  input  logic [NCH-1:0]   aux_en,
  output logic             e,
  output logic             q,
  output logic             e_rise,
  output logic             e_fall,
  output logic             q_rise,
  output logic             q_fall,
  output logic [NCH-1:0]   aux_cen,
  output logic             rst_out
);

  localparam logic [W-1:0] DIV_RST = W'(E_DIV_RST);

  ph_t          ph, ph_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] div_lat, div_nxt;
  logic         term, stall, adv;
  logic         er_nxt, ef_nxt, qr_nxt, qf_nxt;
  logic [RST_STAGES-1:0] rst_sh;

  // Next-state: a terminal count advances the phase unless hold pins ph3.
  // While stalled cnt stays at div_lat so the exit fires on the first
  // cycle hold drops.
  always_comb begin
    term    = (cnt == div_lat);
    stall   = term && (ph == PH_EF) && hold;
    adv     = term && !stall;
    ph_nxt  = ph;
    cnt_nxt = cnt + W'(1);
    div_nxt = div_lat;
    if (term) cnt_nxt = stall ? cnt : '0;
    if (adv) begin
      ph_nxt = ph_t'(ph + 2'd1);
      // Period length only changes on a whole-period boundary.
      if (ph == PH_EF) div_nxt = e_div;
    end
    qr_nxt = adv && (ph == PH_QR);
    er_nxt = adv && (ph == PH_ER);
    qf_nxt = adv && (ph == PH_QF);
    ef_nxt = adv && (ph == PH_EF);
  end

  // Levels and strobes are registered from the same next-state so a
  // strobe is high exactly in the first cycle the new level is visible.
  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      ph      <= PH_QR;
      cnt     <= '0;
      div_lat <= DIV_RST;
      e       <= 1'b0;
      q       <= 1'b0;
      e_rise  <= 1'b0;
      e_fall  <= 1'b0;
      q_rise  <= 1'b0;
      q_fall  <= 1'b0;
    end else begin
      ph      <= ph_nxt;
      cnt     <= cnt_nxt;
      div_lat <= div_nxt;
      e       <= ph_e(ph_nxt);
      q       <= ph_q(ph_nxt);
      e_rise  <= er_nxt;
      e_fall  <= ef_nxt;
      q_rise  <= qr_nxt;
      q_fall  <= qf_nxt;
    end
  end

  // Shifts on the q_fall event itself (not the registered strobe) so
  // rst_out drops in the same cycle as the q_fall strobe.
  always_ff @(posedge clk_base or posedge rst) begin
    if (rst)         rst_sh <= '1;
    else if (qf_nxt) rst_sh <= rst_sh << 1;
  end

  assign rst_out = rst_sh[RST_STAGES-1];

  for (genvar i = 0; i < NCH; i++) begin : g_aux
    cen_div #(.W(W)) u_div (
      .rst      (rst),
      .clk_base (clk_base),
      .en       (aux_en[i]),
      .div      (aux_div[i*W +: W]),
      .cen      (aux_cen[i])
    );
  end

endmodule

// File: tb/tb_cen_quad_gen.sv
module tb_cen_quad_gen;

  localparam int W   = 4;
  localparam int NCH = 2;

  logic             rst;
  logic             clk_base = 1'b0;
  logic [W-1:0]     e_div;
  logic             hold;
  logic [NCH*W-1:0] aux_div;
  logic [NCH-1:0]   aux_en;
  logic             e, q, e_rise, e_fall, q_rise, q_fall, rst_out;
  logic [NCH-1:0]   aux_cen;

  cen_quad_gen #(.W(W), .NCH(NCH), .E_DIV_RST(0), .RST_STAGES(2)) dut (
    .rst      (rst),
    .clk_base (clk_base),
    .e_div    (e_div),
    .hold     (hold),
    .aux_div  (aux_div),
    .aux_en   (aux_en),
    .e        (e),
    .q        (q),
    .e_rise   (e_rise),
    .e_fall   (e_fall),
    .q_rise   (q_rise),
    .q_fall   (q_fall),
    .aux_cen  (aux_cen),
    .rst_out  (rst_out)
  );

  always #5 clk_base = ~clk_base;

  // Observed vector: {e,q,e_rise,e_fall,q_rise,q_fall,rst_out,aux_cen[1:0]}
  localparam logic [8:0] M_MAIN = 9'b111111100;
  localparam logic [8:0] M_AUX  = 9'b000000011;
  localparam logic [8:0] M_ALL  = 9'b111111111;

  typedef struct {
    string      tag;
    logic [8:0] v;
    logic [8:0] m;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push(string tag, logic [8:0] v, logic [8:0] m);
    exp_t x;
    x.tag = tag; x.v = v; x.m = m;
    sb.push_back(x);
  endtask

  // Expected main outputs from the phase table: ph0 (0,0), ph1 (0,1),
  // ph2 (1,1), ph3 (1,0); entering a phase fires its one strobe.
  task automatic push_ph(string tag, int ph, bit stb, bit ro);
    bit ev, qv, er, ef, qr, qf;
    ev = (ph == 2) || (ph == 3);
    qv = (ph == 1) || (ph == 2);
    qr = stb && (ph == 1);
    er = stb && (ph == 2);
    qf = stb && (ph == 3);
    ef = stb && (ph == 0);
    push(tag, {ev, qv, er, ef, qr, qf, ro, 2'b00}, M_MAIN);
  endtask

  task automatic check_now();
    exp_t x;
    logic [8:0] obs;
    obs = {e, q, e_rise, e_fall, q_rise, q_fall, rst_out, aux_cen};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: observed %b, no expected entry", obs);
      return;
    end
    x = sb.pop_front();
    assert ((obs & x.m) === (x.v & x.m)) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (mask %b)", x.tag, obs & x.m, x.v & x.m, x.m);
    end
  endtask

  task automatic tick();
    @(posedge clk_base);
    #1;
    check_now();
  endtask

  task automatic sp(string tag, int ph, bit stb, bit ro);
    push_ph(tag, ph, stb, ro);
    tick();
  endtask

  task automatic sa(string tag, bit a1, bit a0);
    push(tag, {7'b0, a1, a0}, M_AUX);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; e_div = '0; hold = 1'b0; aux_div = '0; aux_en = '0;
    repeat (2) @(posedge clk_base);
    #1;
    push("reset", 9'b000000100, M_ALL);
    check_now();
    rst = 1'b0;

    // 1: e_div=0, 4-cycle period, rst_out drops with the 2nd q_fall
    for (int k = 1; k <= 8; k++) sp("t1_period4", k % 4, 1'b1, k < 7);

    // 2: e_div 0->3 written in ph1; current period stays 4 cycles
    sp("t2_ph1", 1, 1'b1, 1'b0);
    e_div = 4'd3;
    sp("t2_ph2", 2, 1'b1, 1'b0);
    sp("t2_ph3", 3, 1'b1, 1'b0);
    sp("t2_ph0", 0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      sp("t2_quarter4", (k / 4) % 4, (k % 4) == 0, 1'b0);
      if (k == 12) e_div = 4'd1;  // latched at the coming ph3->ph0
    end

    // 3: quarter = 2 cycles; hold in ph1 ignored, hold in ph3 stretches E
    sp("t3_ph0", 0, 1'b0, 1'b0);
    sp("t3_qr", 1, 1'b1, 1'b0);
    hold = 1'b1;
    sp("t3_ph1_hold", 1, 1'b0, 1'b0);
    sp("t3_er_hold", 2, 1'b1, 1'b0);
    hold = 1'b0;
    sp("t3_ph2", 2, 1'b0, 1'b0);
    sp("t3_qf", 3, 1'b1, 1'b0);
    sp("t3_ph3", 3, 1'b0, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) sp("t3_stretch", 3, 1'b0, 1'b0);
    hold = 1'b0;
    sp("t3_ef", 0, 1'b1, 1'b0);

    // 5: reset mid-period, then restart with the reset divider
    sp("t5_ph0", 0, 1'b0, 1'b0);
    sp("t5_qr", 1, 1'b1, 1'b0);
    sp("t5_ph1", 1, 1'b0, 1'b0);
    sp("t5_er", 2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    push("t5_async_rst", 9'b000000100, M_ALL);
    check_now();
    push("t5_in_rst", 9'b000000100, M_ALL);
    tick();
    rst = 1'b0;
    sp("t5_r_qr", 1, 1'b1, 1'b1);
    sp("t5_r_er", 2, 1'b1, 1'b1);
    sp("t5_r_qf1", 3, 1'b1, 1'b1);
    sp("t5_r_ef", 0, 1'b1, 1'b1);
    sp("t5_r_ph0", 0, 1'b0, 1'b1);
    sp("t5_r_qr2", 1, 1'b1, 1'b1);
    sp("t5_r_ph1", 1, 1'b0, 1'b1);
    sp("t5_r_er2", 2, 1'b1, 1'b1);
    sp("t5_r_ph2", 2, 1'b0, 1'b1);
    sp("t5_r_qf2", 3, 1'b1, 1'b0);
    sp("t5_r_ph3", 3, 1'b0, 1'b0);

    // 4: ch0 div 0 every cycle, ch1 div 2 every 3rd; then ch1 div -> 0 at a1=2
    aux_div = {4'd2, 4'd0};
    aux_en  = 2'b11;
    for (int n = 1; n <= 8; n++) sa("t4_aux", (n % 3) == 0, 1'b1);
    aux_div = {4'd0, 4'd0};
    for (int n = 1; n <= 4; n++) sa("t4_drop", 1'b1, 1'b1);

    // 6: enable off then on; first pulse div+1 cycles after re-enable
    aux_div = {4'd3, 4'd1};
    aux_en  = 2'b00;
    for (int n = 1; n <= 4; n++) sa("t6_off", 1'b0, 1'b0);
    aux_en  = 2'b11;
    for (int n = 1; n <= 8; n++) sa("t6_reen", (n % 4) == 0, (n % 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
